// File: rtl/rv32_pkg.sv
// rv32_pkg: shared rv32 pipeline constants and the fetch-to-decode entry type.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam int INSN_BYTES = 4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: imem port and decode-side valid/ready bus of the fetch stage.
interface fetch_buffer_if #(
  parameter int XLEN = 32,
  parameter int CNT_W = 3
);
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_nxt;
  logic [XLEN-1:0] out_instr;
  logic [CNT_W-1:0] count;
  modport master (
    output imem_addr, out_valid, out_pc, out_pc_nxt, out_instr, count,
    input imem_data, out_ready
  );
  modport slave (
    input imem_addr, out_valid, out_pc, out_pc_nxt, out_instr, count,
    output imem_data, out_ready
  );
endinterface

// File: rtl/fetch_buffer_sync_fifo.sv
// sync_fifo: power-of-two deep FIFO with synchronous flush and occupancy count.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [CNT_W-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rdata = mem_q[rd_q];
    count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: owns the PC, fetches one instruction per cycle into a FIFO toward decode.
module fetch_buffer import rv32_pkg::*; #(
  parameter int XLEN = rv32_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = rv32_pkg::RESET_PC
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_en,
  input  logic redirect,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_buffer_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;
  logic [XLEN-1:0] pc_q, pc_d;
  logic push, pop, has, valid;
  entry_t head;
  logic [CNT_W-1:0] cnt;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    has = cnt != '0;
    valid = has & !redirect;
    pop = valid & bus.out_ready;
    push = fetch_en & !redirect & ((cnt < CNT_W'(DEPTH)) | pop);
    pc_d = redirect ? {redirect_pc[XLEN-1:2], 2'b00} : push ? pc_q + XLEN'(INSN_BYTES) : pc_q;
  end
  always_comb begin
    bus.imem_addr = pc_q;
    bus.out_valid = valid;
    bus.count = cnt;
    bus.out_pc = has ? head.pc : '0;
    bus.out_instr = has ? head.instr : '0;
    bus.out_pc_nxt = valid ? head.pc + XLEN'(INSN_BYTES) : '0;
  end
  always_ff @(posedge clk)
    pc_q <= rst ? RESET_PC : pc_d;
  sync_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect),
    .push(push),
    .pop(pop),
    .wdata({pc_q, bus.imem_data}),
    .rdata(head),
    .count(cnt)
  );
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed vector table plus queue-model scoreboard for fetch_buffer.
module tb_fetch_buffer;
  localparam logic [31:0] MASK = 32'hA5A5_0000;
  typedef struct {
    logic rst, en, rd, rdy;
    logic [31:0] rpc;
    int cnt;
    logic vld;
    logic [31:0] pc, addr, addr2;
  } vec_t;
  logic clk = 0, rst, en, rd, rdy;
  logic [31:0] rpc;
  int n_tests = 0, n_fail = 0;
  logic [31:0] q[$];
  logic [31:0] mpc;
  vec_t tbl[$];
  always #5 clk = ~clk;
  fetch_buffer_if #(.XLEN(32), .CNT_W(3)) bus1();
  fetch_buffer_if #(.XLEN(32), .CNT_W(3)) bus2();
  assign bus1.imem_data = bus1.imem_addr ^ MASK;
  assign bus2.imem_data = bus2.imem_addr ^ MASK;
  assign bus1.out_ready = rdy;
  assign bus2.out_ready = rdy;
  fetch_buffer #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_en(en), .redirect(rd), .redirect_pc(rpc), .bus(bus1.master));
  fetch_buffer #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .fetch_en(en), .redirect(rd), .redirect_pc(rpc), .bus(bus2.master));

  function automatic vec_t v(logic r, logic e, logic d, logic [31:0] p, logic y,
                             int c, logic vl, logic [31:0] opc, logic [31:0] a, logic [31:0] a2);
    vec_t t;
    t.rst = r; t.en = e; t.rd = d; t.rpc = p; t.rdy = y;
    t.cnt = c; t.vld = vl; t.pc = opc; t.addr = a; t.addr2 = a2;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t t, input bit use_exp);
    logic mv, pop, push;
    rst = t.rst; en = t.en; rd = t.rd; rpc = t.rpc; rdy = t.rdy;
    @(negedge clk);
    mv = q.size() != 0 && !rd;
    chk("valid", {31'b0, bus1.out_valid}, {31'b0, mv});
    chk("count", {29'b0, bus1.count}, q.size());
    chk("imem_addr", bus1.imem_addr, mpc);
    chk("out_pc", bus1.out_pc, q.size() != 0 ? q[0] : 32'h0);
    chk("out_instr", bus1.out_instr, q.size() != 0 ? q[0] ^ MASK : 32'h0);
    chk("out_pc_nxt", bus1.out_pc_nxt, mv ? q[0] + 32'd4 : 32'h0);
    if (use_exp) begin
      chk("tbl_count", {29'b0, bus1.count}, t.cnt);
      chk("tbl_valid", {31'b0, bus1.out_valid}, {31'b0, t.vld});
      chk("tbl_out_pc", bus1.out_pc, t.pc);
      chk("tbl_addr", bus1.imem_addr, t.addr);
      chk("tbl_wrap_addr", bus2.imem_addr, t.addr2);
    end
    @(posedge clk);
    if (rst) begin
      mpc = 32'h0;
      q.delete();
    end else if (rd) begin
      mpc = {rpc[31:2], 2'b00};
      q.delete();
    end else begin
      pop = mv && rdy;
      push = en && (q.size() < 4 || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
    #1;
  endtask

  initial begin
    tbl.push_back(v(0,1,0,32'h0,  1, 0,0,32'h0,  32'h0,  32'hFFFF_FFF8));
    tbl.push_back(v(0,1,0,32'h0,  1, 1,1,32'h0,  32'h4,  32'hFFFF_FFFC));
    tbl.push_back(v(0,1,0,32'h0,  1, 1,1,32'h4,  32'h8,  32'h0));
    tbl.push_back(v(0,1,0,32'h0,  0, 1,1,32'h8,  32'hC,  32'h4));
    tbl.push_back(v(0,1,0,32'h0,  0, 2,1,32'h8,  32'h10, 32'h8));
    tbl.push_back(v(0,1,0,32'h0,  0, 3,1,32'h8,  32'h14, 32'hC));
    tbl.push_back(v(0,1,0,32'h0,  0, 4,1,32'h8,  32'h18, 32'h10));
    tbl.push_back(v(0,1,0,32'h0,  0, 4,1,32'h8,  32'h18, 32'h10));
    tbl.push_back(v(0,1,0,32'h0,  1, 4,1,32'h8,  32'h18, 32'h10));
    tbl.push_back(v(0,1,0,32'h0,  0, 4,1,32'hC,  32'h1C, 32'h14));
    tbl.push_back(v(0,1,0,32'h0,  1, 4,1,32'hC,  32'h1C, 32'h14));
    tbl.push_back(v(0,0,0,32'h0,  1, 4,1,32'h10, 32'h20, 32'h18));
    tbl.push_back(v(0,1,1,32'h103,1, 3,0,32'h14, 32'h20, 32'h18));
    tbl.push_back(v(0,1,0,32'h0,  1, 0,0,32'h0,  32'h100,32'h100));
    tbl.push_back(v(0,1,0,32'h0,  1, 1,1,32'h100,32'h104,32'h104));
    tbl.push_back(v(0,1,1,32'h200,1, 1,0,32'h104,32'h108,32'h108));
    tbl.push_back(v(0,1,1,32'h301,1, 0,0,32'h0,  32'h200,32'h200));
    tbl.push_back(v(0,1,0,32'h0,  0, 0,0,32'h0,  32'h300,32'h300));
    tbl.push_back(v(0,1,0,32'h0,  0, 1,1,32'h300,32'h304,32'h304));
    tbl.push_back(v(0,1,0,32'h0,  0, 2,1,32'h300,32'h308,32'h308));
    tbl.push_back(v(1,1,1,32'h500,1, 3,0,32'h300,32'h30C,32'h30C));
    tbl.push_back(v(0,0,0,32'h0,  1, 0,0,32'h0,  32'h0,  32'hFFFF_FFF8));
    tbl.push_back(v(0,0,0,32'h0,  1, 0,0,32'h0,  32'h0,  32'hFFFF_FFF8));
    rst = 1; en = 0; rd = 0; rpc = 0; rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    mpc = 32'h0;
    foreach (tbl[i]) step(tbl[i], 1'b1);
    for (int i = 0; i < 400; i++) begin
      vec_t t;
      t = v($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 2) != 0,
            0, 0, 0, 0, 0);
      step(t, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
